// File: rtl/sound_scheduler_pkg.sv
// Shared note encoding, tone half-periods and per-requester note sequences for sound_scheduler.
package sound_pkg;

   typedef enum logic [1:0] {
      NOTE_C = 2'd0,
      NOTE_D = 2'd1,
      NOTE_E = 2'd2,
      NOTE_G = 2'd3
   } note_e;

   localparam int unsigned HALF_C  = 2986;
   localparam int unsigned HALF_D  = 2660;
   localparam int unsigned HALF_E  = 2369;
   localparam int unsigned HALF_G  = 1993;
   localparam int unsigned HALF_W  = $clog2(HALF_C + 1);
   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned ID_W    = 2;
   localparam int unsigned IDX_W   = 2;

   // One requester's melody: index of its last note plus up to four notes.
   typedef struct packed {
      logic [IDX_W-1:0] last;
      note_e            n0;
      note_e            n1;
      note_e            n2;
      note_e            n3;
   } seq_t;

   function automatic seq_t seq_entry(input logic [ID_W-1:0] id);
      seq_t s;
      case (id)
         2'd0:    s = '{last: 2'd0, n0: NOTE_C, n1: NOTE_C, n2: NOTE_C, n3: NOTE_C};
         2'd1:    s = '{last: 2'd0, n0: NOTE_D, n1: NOTE_C, n2: NOTE_C, n3: NOTE_C};
         2'd2:    s = '{last: 2'd1, n0: NOTE_E, n1: NOTE_G, n2: NOTE_C, n3: NOTE_C};
         default: s = '{last: 2'd3, n0: NOTE_G, n1: NOTE_E, n2: NOTE_D, n3: NOTE_C};
      endcase
      return s;
   endfunction

   function automatic note_e note_at(input seq_t s, input logic [IDX_W-1:0] idx);
      note_e n;
      case (idx)
         2'd0:    n = s.n0;
         2'd1:    n = s.n1;
         2'd2:    n = s.n2;
         default: n = s.n3;
      endcase
      return n;
   endfunction

   // Half-period after the simulation shift; never allowed to collapse to zero.
   function automatic logic [HALF_W-1:0] half_limit(input note_e n, input int unsigned shift);
      int unsigned h;
      case (n)
         NOTE_C:  h = HALF_C;
         NOTE_D:  h = HALF_D;
         NOTE_E:  h = HALF_E;
         default: h = HALF_G;
      endcase
      h = h >> shift;
      if (h == 0) h = 1;
      return HALF_W'(h);
   endfunction

endpackage

// File: rtl/sound_scheduler_if.sv
// Request/audio bundle between the game logic and sound_scheduler.
interface sound_scheduler_if;
   import sound_pkg::*;

   logic [NUM_REQ-1:0] req;
   logic               tone_out;
   logic               busy;
   logic [ID_W-1:0]    active_id;
   logic [1:0]         note_code;
   logic               done;

   modport master (output req, input tone_out, busy, active_id, note_code, done);
   modport slave  (input req, output tone_out, busy, active_id, note_code, done);
endinterface

// File: rtl/sound_scheduler_tone_gen.sv
// Square-wave generator: toggles every half cycles while enabled, silent and restarted otherwise.
module tone_gen
   import sound_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              load,
   input  logic [HALF_W-1:0] half,
   output logic              tone
);
   logic [HALF_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         tone  <= 1'b0;
      end else if (load || !en) begin
         cnt_q <= '0;
         tone  <= 1'b0;
      end else if (cnt_q == half - HALF_W'(1)) begin
         cnt_q <= '0;
         tone  <= ~tone;
      end else begin
         cnt_q <= cnt_q + HALF_W'(1);
      end
   end
endmodule

// File: rtl/sound_scheduler.sv
// Fixed-priority scheduler that plays one requester's note sequence at a time on the shared tone.
// Build macro SOUND_PREEMPT_EN lets a higher-priority pending request abort the running sequence.
module sound_scheduler
   import sound_pkg::*;
#(
   parameter int unsigned NOTE_LEN   = 2500000,
   parameter int unsigned GAP_LEN    = 250000,
   parameter int unsigned TONE_SHIFT = 0
) (
   input logic              clk,
   input logic              reset_n,
   sound_scheduler_if.slave bus
);
   localparam int unsigned      DUR_MAX   = (NOTE_LEN > GAP_LEN) ? NOTE_LEN : GAP_LEN;
   localparam int unsigned      DUR_W     = $clog2(DUR_MAX + 1);
   localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(NOTE_LEN - 1);
   localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'(GAP_LEN - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP} state_e;

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] pending_q, pending_d;
   logic [ID_W-1:0]    active_q, active_d;
   note_e              note_q, note_d;
   seq_t               seq_q, seq_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [DUR_W-1:0]   dur_q, dur_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               tone_en_c, tone_load_c, preempt_c, tone;
   logic [ID_W-1:0]    grant_c;
   logic [HALF_W-1:0]  half_c;

   // Highest set pending bit wins.
   always_comb begin
      grant_c = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (pending_q[i]) grant_c = ID_W'(i);
   end

`ifdef SOUND_PREEMPT_EN
   always_comb begin
      preempt_c = 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
         if (pending_q[i] && (ID_W'(i) > active_q)) preempt_c = 1'b1;
   end
`else
   assign preempt_c = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      active_d    = active_q;
      note_d      = note_q;
      seq_d       = seq_q;
      idx_d       = idx_q;
      dur_d       = dur_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      tone_en_c   = 1'b0;
      tone_load_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pending_q != '0) begin
               pending_d[grant_c] = 1'b0;
               active_d    = grant_c;
               seq_d       = seq_entry(grant_c);
               note_d      = note_at(seq_entry(grant_c), '0);
               idx_d       = '0;
               dur_d       = '0;
               busy_d      = 1'b1;
               tone_load_c = 1'b1;
               state_d     = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (preempt_c) begin
               dur_d   = '0;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (dur_q == NOTE_LAST) begin
               dur_d = '0;
               if (idx_q == seq_q.last) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_GAP;
               end
            end else begin
               dur_d     = dur_q + DUR_W'(1);
               tone_en_c = 1'b1;
            end
         end
         ST_GAP: begin
            if (preempt_c) begin
               dur_d   = '0;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (dur_q == GAP_LAST) begin
               dur_d       = '0;
               idx_d       = idx_q + IDX_W'(1);
               note_d      = note_at(seq_q, idx_q + IDX_W'(1));
               tone_load_c = 1'b1;
               state_d     = ST_PLAY;
            end else begin
               dur_d = dur_q + DUR_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A new request pulse overrides the grant clear of the same cycle.
      pending_d = pending_d | bus.req;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
         active_q  <= '0;
         note_q    <= NOTE_C;
         seq_q     <= '0;
         idx_q     <= '0;
         dur_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         active_q  <= active_d;
         note_q    <= note_d;
         seq_q     <= seq_d;
         idx_q     <= idx_d;
         dur_q     <= dur_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign half_c = half_limit(note_q, TONE_SHIFT);

   tone_gen u_tone_gen (
      .clk  (clk),
      .rst_n(reset_n),
      .en   (tone_en_c),
      .load (tone_load_c),
      .half (half_c),
      .tone (tone)
   );

   assign bus.tone_out  = tone;
   assign bus.busy      = busy_q;
   assign bus.active_id = active_q;
   assign bus.note_code = note_q;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_sound_scheduler.sv
// Directed bench for sound_scheduler with shortened notes (20 clks), gaps (4 clks) and tones.
module tb_sound_scheduler;
   localparam int NOTE_LEN = 20;
   localparam int GAP_LEN  = 4;

   logic clk = 1'b0;
   logic reset_n;
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   pulse_at [3];
   logic [3:0] pulse_val [3];

   sound_scheduler_if bus ();

   sound_scheduler #(.NOTE_LEN(NOTE_LEN), .GAP_LEN(GAP_LEN), .TONE_SHIFT(8)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      int         id;
      int         n;
      logic [1:0] notes [4];
   } vec_t;

   vec_t tbl [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Half-periods after >>8: C=11, D=10, E=9, G=7.
   function automatic int hp(input logic [1:0] n);
      case (n)
         2'd0:    return 11;
         2'd1:    return 10;
         2'd2:    return 9;
         default: return 7;
      endcase
   endfunction

   task automatic clear_pulses();
      for (int i = 0; i < 3; i++) begin
         pulse_at[i]  = -1;
         pulse_val[i] = 4'b0;
      end
   endtask

   task automatic drive_req(input int c);
      logic [3:0] r;
      r = 4'b0;
      for (int i = 0; i < 3; i++)
         if (pulse_at[i] == c) r = r | pulse_val[i];
      bus.req = r;
   endtask

   // Starts on the first PLAY cycle; returns positioned on the done cycle.
   task automatic play_seq(input int id, input int n, input logic [1:0] nt [4]);
      int c;
      c = 0;
      for (int k = 0; k < n; k++) begin
         for (int d = 0; d < NOTE_LEN; d++) begin
            drive_req(c);
            chk("play_busy", int'(bus.busy), 1);
            chk("play_done", int'(bus.done), 0);
            chk("play_id", int'(bus.active_id), id);
            chk("play_note", int'(bus.note_code), int'(nt[k]));
            chk("play_tone", int'(bus.tone_out), (d / hp(nt[k])) % 2);
            tick();
            c++;
         end
         if (k < n - 1) begin
            for (int g = 0; g < GAP_LEN; g++) begin
               drive_req(c);
               chk("gap_busy", int'(bus.busy), 1);
               chk("gap_tone", int'(bus.tone_out), 0);
               tick();
               c++;
            end
         end
      end
      bus.req = 4'b0;
      chk("end_done", int'(bus.done), 1);
      chk("end_busy", int'(bus.busy), 0);
      chk("end_tone", int'(bus.tone_out), 0);
      chk("end_id", int'(bus.active_id), id);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{req: 4'b0001, id: 0, n: 1, notes: '{2'd0, 2'd0, 2'd0, 2'd0}};
      tbl[1] = '{req: 4'b0010, id: 1, n: 1, notes: '{2'd1, 2'd0, 2'd0, 2'd0}};
      tbl[2] = '{req: 4'b0100, id: 2, n: 2, notes: '{2'd2, 2'd3, 2'd0, 2'd0}};
      tbl[3] = '{req: 4'b1000, id: 3, n: 4, notes: '{2'd3, 2'd2, 2'd1, 2'd0}};

      clear_pulses();
      bus.req = 4'b0;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tone", int'(bus.tone_out), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_id", int'(bus.active_id), 0);
      chk("rst_note", int'(bus.note_code), 0);
      chk("rst_done", int'(bus.done), 0);
      reset_n = 1'b1;
      tick();

      // Each requester alone: 2-clk grant latency, its melody, then a single done.
      for (int i = 0; i < 4; i++) begin
         bus.req = tbl[i].req;
         tick();
         bus.req = 4'b0;
         chk("lat_busy0", int'(bus.busy), 0);
         tick();
         play_seq(tbl[i].id, tbl[i].n, tbl[i].notes);
         tick();
         chk("post_done", int'(bus.done), 0);
         chk("post_busy", int'(bus.busy), 0);
         chk("note_hold", int'(bus.note_code), int'(tbl[i].notes[tbl[i].n - 1]));
         repeat (2) tick();
      end

      // Simultaneous brick + paddle: brick first, one idle cycle, then paddle.
      bus.req = 4'b0101;
      tick();
      bus.req = 4'b0;
      tick();
      play_seq(2, 2, tbl[2].notes);
      tick();
      play_seq(0, 1, tbl[0].notes);
      tick();
      chk("bb_done", int'(bus.done), 0);
      chk("bb_busy", int'(bus.busy), 0);
      repeat (2) tick();

      // Repeated wall pulse is absorbed; paddle waits; both served once after lost.
      bus.req = 4'b1000;
      tick();
      bus.req = 4'b0;
      tick();
      pulse_at[0] = 3;  pulse_val[0] = 4'b0010;
      pulse_at[1] = 5;  pulse_val[1] = 4'b0010;
      pulse_at[2] = 10; pulse_val[2] = 4'b0001;
      play_seq(3, 4, tbl[3].notes);
      clear_pulses();
      tick();
      play_seq(1, 1, tbl[1].notes);
      tick();
      play_seq(0, 1, tbl[0].notes);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("once_busy", int'(bus.busy), 0);
         chk("once_done", int'(bus.done), 0);
      end

      // Lost request arrives at dur=5 of a paddle note.
      bus.req = 4'b0001;
      tick();
      bus.req = 4'b0;
      tick();
`ifdef SOUND_PREEMPT_EN
      for (int c = 0; c < 7; c++) begin
         bus.req = (c == 5) ? 4'b1000 : 4'b0000;
         chk("pre_busy", int'(bus.busy), 1);
         chk("pre_tone", int'(bus.tone_out), 0);
         tick();
      end
      bus.req = 4'b0;
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_done", int'(bus.done), 0);
      chk("abort_tone", int'(bus.tone_out), 0);
      tick();
      play_seq(3, 4, tbl[3].notes);
`else
      pulse_at[0] = 5; pulse_val[0] = 4'b1000;
      play_seq(0, 1, tbl[0].notes);
      clear_pulses();
      tick();
      play_seq(3, 4, tbl[3].notes);
`endif
      tick();
      chk("pre_end_busy", int'(bus.busy), 0);
      chk("pre_end_done", int'(bus.done), 0);
      repeat (2) tick();

      // Reset during a brick gap with paddle pending.
      bus.req = 4'b0100;
      tick();
      bus.req = 4'b0;
      tick();
      for (int c = 0; c < 22; c++) begin
         bus.req = (c == 3) ? 4'b0001 : 4'b0000;
         chk("rg_busy", int'(bus.busy), 1);
         tick();
      end
      chk("rg_gap_tone", int'(bus.tone_out), 0);
      chk("rg_gap_id", int'(bus.active_id), 2);
      reset_n = 1'b0;
      #1;
      chk("rg_tone", int'(bus.tone_out), 0);
      chk("rg_busy0", int'(bus.busy), 0);
      chk("rg_id", int'(bus.active_id), 0);
      chk("rg_note", int'(bus.note_code), 0);
      chk("rg_done", int'(bus.done), 0);
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rg_idle_busy", int'(bus.busy), 0);
         chk("rg_idle_done", int'(bus.done), 0);
      end
      bus.req = 4'b0010;
      tick();
      bus.req = 4'b0;
      tick();
      play_seq(1, 1, tbl[1].notes);
      tick();
      chk("final_done", int'(bus.done), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/sound_scheduler.md
Name: sound_scheduler

Overview:
- Shares the single square-wave tone generator between game sound requesters: paddle hit, brick hit, wall hit and ball lost.
- Latches one-cycle event pulses from the ball/paddle logic and grants one requester at a time by fixed priority.
- Plays that requester's short note sequence (C/D/E/G), then returns to idle.
- Sits between the ball block's play_sound strobes and the audio output pin, in the 50 MHz domain.

Parameters:
- NOTE_LEN, 2500000, clk cycles each note sounds (50 ms).
- GAP_LEN, 250000, silent clk cycles between consecutive notes of one sequence.
- TONE_SHIFT, 0, right-shift applied to every note half-period constant; used for simulation speed-up.

Ports:
- clk  in  1  50 MHz system clock.
- reset_n  in  1  asynchronous active-low reset.
- req  in  4  one-cycle event pulses: [0] paddle, [1] wall, [2] brick, [3] ball lost. Highest index has highest priority.
- tone_out  out  1  square-wave audio output.
- busy  out  1  high while any sequence is playing, including gaps.
- active_id  out  2  index of the requester currently being served.
- note_code  out  2  note currently sounding: 0=C, 1=D, 2=E, 3=G.
- done  out  1  one-cycle pulse when a sequence completes.

Behaviour:
- Reset (async assert, sync release): all outputs 0, pending=0, FSM=IDLE, all counters 0.
- pending[3:0]: bit i is set on the clk after req[i]=1. Set wins over a same-cycle clear. A repeated req while the bit is already pending is absorbed (no queue depth).
- FSM states: IDLE, PLAY, GAP.
- IDLE, pending≠0:
  - Select highest set bit i and clear it.
  - Set active_id=i, seq_len and notes from the table, note_idx=0, dur=0, half-period counter=0, tone_out=0.
  - Next state PLAY; busy=1 from that cycle.
- PLAY:
  - Half-period counter counts to (HALF[note]>>TONE_SHIFT)-1, then wraps to 0 and toggles tone_out.
  - dur counts 0..NOTE_LEN-1. At NOTE_LEN-1, tone_out is forced to 0 next cycle.
  - If the note is the last in the sequence: go to IDLE, pulse done for 1 cycle, busy=0.
  - Otherwise: go to GAP with dur=0.
- GAP: tone_out=0. After GAP_LEN cycles, note_idx+1, counters reset, go to PLAY.
- Latency: request pulse to first PLAY cycle is 2 clks when idle.
- Back-to-back: if pending≠0 when a sequence ends, IDLE lasts exactly 1 cycle (done=1, busy=0) before the next grant.
- Counter widths: $clog2(max+1) of each limit. A half-period of 0 after shifting is clamped to 1.
- note_code is valid only while busy. It holds its last value when idle.

Optional Feature:
- Macro: SOUND_PREEMPT_EN.
- Defined: in PLAY or GAP, if a pending bit with index > active_id is set, the current sequence aborts on the next clk without asserting done. The FSM then takes the IDLE grant path immediately (1 idle cycle). The aborted requester is not re-queued.
- Undefined: the running sequence always completes; higher-priority requests wait in pending.

Decomposition:
- Shared package sound_pkg holds:
  - note enum (C,D,E,G);
  - half-period constants HALF_C=2986, HALF_D=2660, HALF_E=2369, HALF_G=1993;
  - per-requester sequence table: paddle {C}; wall {D}; brick {E,G}; lost {G,E,D,C}, with lengths 1,1,2,4.
- One sub-module: tone_gen. It takes the half-period limit and an enable, produces the square wave, and restarts on a load strobe.

Test Plan (NOTE_LEN=20, GAP_LEN=4, TONE_SHIFT=8 → half-periods 11,10,9,7):
- Single req[0] pulse → busy after 2 clks; C tone toggles every 11 clks for 20 clks; then done pulse, busy=0, active_id=0.
- req[3] pulse → note_code G,E,D,C, each 20 clks, separated by 4-clk gaps with tone_out=0; one done pulse at the end.
- req[0] and req[2] in the same cycle → brick sequence (E,G) first, 1 idle cycle, then paddle C; two done pulses.
- req[1] pulsed while req[1] is already pending, and req[0] pulsed during an active sequence → each served exactly once, in priority order after the current one.
- req[0] playing, req[3] at dur=5 → with SOUND_PREEMPT_EN: abort, no done, lost sequence starts 2 clks later; without it: C finishes, then lost sequence.
- reset_n low mid-GAP → all outputs 0 immediately, pending cleared, no done; after release, a new req is served normally.
